// File: rtl/i2c_cfg_pkg.sv
// Shared types and constants for the I2C configuration target.
package i2c_cfg_pkg;

  // Protocol state machine states.
  typedef enum logic [3:0] {
    StIdle,
    StAddr,
    StAddrAck,
    StPtr,
    StPtrAck,
    StWdata,
    StWdataAck,
    StRdata,
    StRack,
    StWaitStop
  } i2c_state_e;

  localparam int unsigned CFG_BYTES = 12;

  localparam logic [3:0] REG_CFG_LAST = 4'hB;
  localparam logic [3:0] REG_STAT_LO  = 4'hC;
  localparam logic [3:0] REG_STAT_HI  = 4'hD;
  localparam logic [3:0] REG_ID       = 4'hE;

endpackage

// File: rtl/i2c_line_sync.sv
// Two-flop synchroniser plus edge detector for one I2C line.
// Define I2C_CFG_TARGET_FILTER_EN to add a 3-sample stability filter after the synchroniser.
module i2c_line_sync (
  input  logic clk_i,
  input  logic rst_i,
  input  logic pin_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic meta_q, sync_q;
  logic stage;
  logic lvl_q, rise_q, fall_q;

  // Synchronise the raw pin; idle bus level is high.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= pin_i;
      sync_q <= meta_q;
    end
  end

`ifdef I2C_CFG_TARGET_FILTER_EN
  logic       filt_q;
  logic [1:0] run_q;

  // Accept a new level only after three consecutive samples disagree with the current one.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      filt_q <= 1'b1;
      run_q  <= '0;
    end else if (sync_q == filt_q) begin
      run_q <= '0;
    end else if (run_q == 2'd2) begin
      filt_q <= sync_q;
      run_q  <= '0;
    end else begin
      run_q <= run_q + 2'd1;
    end
  end

  assign stage = filt_q;
`else
  assign stage = sync_q;
`endif

  // Registered edge detect; level_o is aligned with the edge pulses.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      lvl_q  <= 1'b1;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      lvl_q  <= stage;
      rise_q <= stage & ~lvl_q;
      fall_q <= ~stage & lvl_q;
    end
  end

  assign level_o = lvl_q;
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;

endmodule

// File: rtl/i2c_cfg_target.sv
// I2C target exposing a 12-byte config shadow, a 16-bit status snapshot and an ID byte.
// Optional line filter: I2C_CFG_TARGET_FILTER_EN (see i2c_line_sync).
module i2c_cfg_target
  import i2c_cfg_pkg::*;
#(
  parameter logic [6:0]  TARGET_ADDR = 7'h42,
  parameter logic [95:0] CFG_RESET   = 96'h0,
  parameter logic [7:0]  ID_BYTE     = 8'hA5
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        scl_i,
  input  logic        sda_i,
  output logic        sda_oe_o,
  output logic [95:0] cfg_o,
  output logic        cfg_strobe_o,
  input  logic [15:0] status_i,
  output logic        busy_o
);

  logic scl_lvl, scl_rise, scl_fall;
  logic sda_lvl, sda_rise, sda_fall;

  i2c_line_sync u_scl_sync (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .pin_i  (scl_i),
    .level_o(scl_lvl),
    .rise_o (scl_rise),
    .fall_o (scl_fall)
  );

  i2c_line_sync u_sda_sync (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .pin_i  (sda_i),
    .level_o(sda_lvl),
    .rise_o (sda_rise),
    .fall_o (sda_fall)
  );

  i2c_state_e                  state_q, state_d;
  logic [3:0]                  cnt_q, cnt_d;
  logic [7:0]                  shift_q, shift_d;
  logic [7:0]                  txb_q, txb_d;
  logic [3:0]                  ptr_q, ptr_d;
  logic                        dirty_q, dirty_d;
  logic [CFG_BYTES-1:0][7:0]   shadow_q, shadow_d;
  logic [95:0]                 cfg_q, cfg_d;
  logic                        strobe_q, strobe_d;
  logic                        busy_q, busy_d;
  logic                        oe_q, oe_d;
  logic [15:0]                 snap_q, snap_d;

  logic       start_det, stop_det, byte_done;
  logic [3:0] rd_ptr;
  logic [7:0] rd_byte;

  assign start_det = sda_fall & scl_lvl;
  assign stop_det  = sda_rise & scl_lvl;
  assign byte_done = scl_fall && (cnt_q == 4'd8);

  // Byte to load for the next read; after a master ACK it is the following register.
  always_comb begin
    rd_ptr  = (state_q == StRack) ? ptr_q + 4'd1 : ptr_q;
    rd_byte = 8'h00;
    if (rd_ptr <= REG_CFG_LAST)     rd_byte = shadow_q[rd_ptr];
    else if (rd_ptr == REG_STAT_LO) rd_byte = snap_q[7:0];
    else if (rd_ptr == REG_STAT_HI) rd_byte = snap_q[15:8];
    else if (rd_ptr == REG_ID)      rd_byte = ID_BYTE;
  end

  // Next-state logic; START/STOP take priority over any bit-level activity.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shift_d  = shift_q;
    txb_d    = txb_q;
    ptr_d    = ptr_q;
    dirty_d  = dirty_q;
    shadow_d = shadow_q;
    cfg_d    = cfg_q;
    strobe_d = 1'b0;
    busy_d   = busy_q;
    oe_d     = oe_q;
    snap_d   = snap_q;

    if (start_det || stop_det) begin
      state_d = start_det ? StAddr : StIdle;
      cnt_d   = '0;
      oe_d    = 1'b0;
      busy_d  = 1'b0;
      if (dirty_q) begin
        cfg_d    = shadow_q;
        strobe_d = 1'b1;
        dirty_d  = 1'b0;
      end
    end else begin
      if ((state_q inside {StAddr, StPtr, StWdata}) && scl_rise && (cnt_q != 4'd8)) begin
        shift_d = {shift_q[6:0], sda_lvl};
        cnt_d   = cnt_q + 4'd1;
      end
      unique case (state_q)
        StAddr: begin
          if (scl_rise && (cnt_q == 4'd7)) begin
            // shift_q[6:0] holds the address, the incoming bit is R/W.
            if (shift_q[6:0] == TARGET_ADDR) begin
              busy_d = 1'b1;
              if (sda_lvl) snap_d = status_i;
            end else begin
              state_d = StWaitStop;
            end
          end else if (byte_done) begin
            state_d = StAddrAck;
            oe_d    = 1'b1;
            cnt_d   = '0;
          end
        end
        StAddrAck: begin
          if (scl_fall) begin
            oe_d  = 1'b0;
            cnt_d = '0;
            if (shift_q[0]) begin
              state_d = StRdata;
              txb_d   = rd_byte;
              oe_d    = ~rd_byte[7];
            end else begin
              state_d = StPtr;
            end
          end
        end
        StPtr: begin
          if (byte_done) begin
            ptr_d   = shift_q[3:0];
            state_d = StPtrAck;
            oe_d    = 1'b1;
            cnt_d   = '0;
          end
        end
        StWdata: begin
          if (byte_done) begin
            if (ptr_q <= REG_CFG_LAST) begin
              shadow_d[ptr_q] = shift_q;
              dirty_d         = 1'b1;
            end
            ptr_d   = ptr_q + 4'd1;
            state_d = StWdataAck;
            oe_d    = 1'b1;
            cnt_d   = '0;
          end
        end
        StPtrAck, StWdataAck: begin
          if (scl_fall) begin
            oe_d    = 1'b0;
            state_d = StWdata;
          end
        end
        StRdata: begin
          if (scl_rise && (cnt_q != 4'd8)) begin
            cnt_d = cnt_q + 4'd1;
          end else if (byte_done) begin
            oe_d    = 1'b0;
            state_d = StRack;
            cnt_d   = '0;
          end else if (scl_fall) begin
            oe_d  = ~txb_q[6];
            txb_d = {txb_q[6:0], 1'b0};
          end
        end
        StRack: begin
          if (scl_rise) begin
            shift_d = {shift_q[6:0], sda_lvl};
            cnt_d   = 4'd1;
          end else if (scl_fall && (cnt_q == 4'd1)) begin
            cnt_d = '0;
            if (!shift_q[0]) begin
              ptr_d   = ptr_q + 4'd1;
              txb_d   = rd_byte;
              oe_d    = ~rd_byte[7];
              state_d = StRdata;
            end else begin
              state_d = StWaitStop;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      shift_q  <= '0;
      txb_q    <= '0;
      ptr_q    <= '0;
      dirty_q  <= 1'b0;
      shadow_q <= CFG_RESET;
      cfg_q    <= CFG_RESET;
      strobe_q <= 1'b0;
      busy_q   <= 1'b0;
      oe_q     <= 1'b0;
      snap_q   <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shift_q  <= shift_d;
      txb_q    <= txb_d;
      ptr_q    <= ptr_d;
      dirty_q  <= dirty_d;
      shadow_q <= shadow_d;
      cfg_q    <= cfg_d;
      strobe_q <= strobe_d;
      busy_q   <= busy_d;
      oe_q     <= oe_d;
      snap_q   <= snap_d;
    end
  end

  assign sda_oe_o     = oe_q;
  assign cfg_o        = cfg_q;
  assign cfg_strobe_o = strobe_q;
  assign busy_o       = busy_q;

endmodule

// File: tb/tb_i2c_cfg_target.sv
// Self-checking bench for i2c_cfg_target: bit-banged I2C master, register model, commit scoreboard.
module tb_i2c_cfg_target;

  localparam int Q = 100;  // quarter SCL period (10 clk cycles)

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        m_scl = 1'b1;
  logic        m_sda = 1'b1;
  logic        sda_line;
  logic        sda_oe, strobe, busy;
  logic [95:0] cfg;
  logic [15:0] status = 16'h0;

  assign sda_line = m_sda & ~sda_oe;

  always #5 clk = ~clk;

  i2c_cfg_target dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .scl_i       (m_scl),
    .sda_i       (sda_line),
    .sda_oe_o    (sda_oe),
    .cfg_o       (cfg),
    .cfg_strobe_o(strobe),
    .status_i    (status),
    .busy_o      (busy)
  );

  int passed = 0;
  int total  = 0;

  // Register model
  logic [7:0]  m_shadow [12];
  logic [95:0] m_cfg;
  logic [3:0]  m_ptr;
  logic        m_dirty;
  logic [15:0] m_snap;

  // Scoreboards
  logic [95:0] exp_q [$];
  logic [95:0] obs_q [$];
  logic [7:0]  rexp_q [$];

  int   strobes = 0;
  logic oe_seen = 1'b0;
  logic busy_seen = 1'b0;

  always @(negedge clk) begin
    if (strobe) begin
      strobes++;
      obs_q.push_back(cfg);
    end
    if (sda_oe) oe_seen = 1'b1;
    if (busy) busy_seen = 1'b1;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [95:0] mdl_pack();
    logic [95:0] v;
    for (int i = 0; i < 12; i++) v[i*8 +: 8] = m_shadow[i];
    return v;
  endfunction

  function automatic logic [7:0] mdl_rd(input logic [3:0] p);
    if (p <= 4'hB) return m_shadow[p];
    case (p)
      4'hC:    return m_snap[7:0];
      4'hD:    return m_snap[15:8];
      4'hE:    return 8'hA5;
      default: return 8'h00;
    endcase
  endfunction

  task automatic mdl_reset();
    for (int i = 0; i < 12; i++) m_shadow[i] = 8'h00;
    m_cfg = '0; m_ptr = '0; m_dirty = 1'b0; m_snap = '0;
    exp_q.delete(); obs_q.delete(); rexp_q.delete();
  endtask

  task automatic mdl_write(input logic [7:0] b);
    if (m_ptr <= 4'hB) begin
      m_shadow[m_ptr] = b;
      m_dirty = 1'b1;
    end
    m_ptr = m_ptr + 4'd1;
  endtask

  task automatic mdl_commit();
    if (m_dirty) begin
      m_cfg = mdl_pack();
      exp_q.push_back(m_cfg);
      m_dirty = 1'b0;
    end
  endtask

  // Bus primitives (no checking)
  task automatic bus_start();
    m_sda = 1'b1; #Q; m_scl = 1'b1; #Q; m_sda = 1'b0; #Q; m_scl = 1'b0; #Q;
    mdl_commit();
  endtask

  task automatic bus_stop();
    m_sda = 1'b0; #Q; m_scl = 1'b1; #Q; m_sda = 1'b1; #(2*Q);
    mdl_commit();
  endtask

  task automatic send_bit(input logic b);
    m_sda = b; #Q; m_scl = 1'b1; #(2*Q); m_scl = 1'b0; #Q;
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    m_sda = 1'b1; #Q; m_scl = 1'b1; #Q; ack = sda_line; #Q; m_scl = 1'b0; #Q;
  endtask

  task automatic recv_byte(input logic nack, output logic [7:0] b);
    m_sda = 1'b1;
    for (int i = 7; i >= 0; i--) begin
      #Q; m_scl = 1'b1; #Q; b[i] = sda_line; #Q; m_scl = 1'b0; #Q;
    end
    m_sda = nack; #Q; m_scl = 1'b1; #(2*Q); m_scl = 1'b0; #Q;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    mdl_reset();
    @(negedge clk);
    total++; if (cfg !== 96'h0) $display("FAIL reset_cfg: got %h want %h", cfg, 96'h0); else passed++;
    total++; if (sda_oe !== 1'b0) $display("FAIL reset_oe: got %b want 0", sda_oe); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else passed++;
    total++; if (strobe !== 1'b0) $display("FAIL reset_strobe: got %b want 0", strobe); else passed++;
  endtask

  task automatic test_addressed_write();
    logic ack;
    logic [7:0] d [2];
    logic [95:0] e, o;
    int s0;
    d[0] = 8'hC4; d[1] = 8'h09;
    s0 = strobes;
    bus_start();
    send_byte(8'h84, ack);
    total++; if (ack !== 1'b0) $display("FAIL wr_addr_ack: got %b want 0", ack); else passed++;
    total++; if (busy !== 1'b1) $display("FAIL wr_busy: got %b want 1", busy); else passed++;
    send_byte(8'h00, ack); m_ptr = 4'h0;
    total++; if (ack !== 1'b0) $display("FAIL wr_ptr_ack: got %b want 0", ack); else passed++;
    for (int i = 0; i < 2; i++) begin
      send_byte(d[i], ack); mdl_write(d[i]);
      total++; if (ack !== 1'b0) $display("FAIL wr_data_ack[%0d]: got %b want 0", i, ack); else passed++;
    end
    total++; if (strobes != s0) $display("FAIL wr_early_strobe: got %0d want %0d", strobes, s0); else passed++;
    bus_stop();
    total++; if (strobes != s0 + 1) $display("FAIL wr_strobes: got %0d want %0d", strobes, s0 + 1); else passed++;
    total++;
    if (obs_q.size() == 0 || exp_q.size() == 0) $display("FAIL wr_commit: got %0d commits want %0d", obs_q.size(), exp_q.size());
    else begin
      o = obs_q.pop_front(); e = exp_q.pop_front();
      if (o !== e) $display("FAIL wr_commit: got %h want %h", o, e); else passed++;
    end
    total++; if (cfg[15:0] !== 16'h09C4) $display("FAIL wr_cfg_lo: got %h want 09c4", cfg[15:0]); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL wr_busy_after_stop: got %b want 0", busy); else passed++;
  endtask

  task automatic test_wrong_address();
    logic ack;
    int s0;
    s0 = strobes;
    oe_seen = 1'b0; busy_seen = 1'b0;
    bus_start();
    send_byte(8'h86, ack);
    total++; if (ack !== 1'b1) $display("FAIL wa_nack: got %b want 1", ack); else passed++;
    send_byte(8'h55, ack);
    bus_stop();
    total++; if (oe_seen !== 1'b0) $display("FAIL wa_sda_driven: got %b want 0", oe_seen); else passed++;
    total++; if (busy_seen !== 1'b0) $display("FAIL wa_busy: got %b want 0", busy_seen); else passed++;
    total++; if (strobes != s0) $display("FAIL wa_strobe: got %0d want %0d", strobes, s0); else passed++;
  endtask

  task automatic test_read_snapshot();
    logic ack;
    logic [7:0] b, e;
    logic [7:0] got [2];
    int s0;
    s0 = strobes;
    status = 16'h044C;
    bus_start();
    send_byte(8'h84, ack);
    send_byte(8'h0C, ack); m_ptr = 4'hC;
    total++; if (ack !== 1'b0) $display("FAIL rd_ptr_ack: got %b want 0", ack); else passed++;
    bus_start();
    send_byte(8'h85, ack); m_snap = status;
    total++; if (ack !== 1'b0) $display("FAIL rd_addr_ack: got %b want 0", ack); else passed++;
    for (int i = 0; i < 2; i++) begin
      rexp_q.push_back(mdl_rd(m_ptr));
      recv_byte(i == 1, b);
      got[i] = b;
      if (i == 0) begin
        m_ptr = m_ptr + 4'd1;
        status = 16'hBEEF;
      end
      e = rexp_q.pop_front();
      total++; if (b !== e) $display("FAIL rd_byte[%0d]: got %h want %h", i, b, e); else passed++;
    end
    bus_stop();
    total++; if (got[0] !== 8'h4C) $display("FAIL rd_stat_lo: got %h want 4c", got[0]); else passed++;
    total++; if (got[1] !== 8'h04) $display("FAIL rd_stat_hi: got %h want 04", got[1]); else passed++;
    // ID byte, reserved register and wrap back into the config shadow.
    bus_start();
    send_byte(8'h84, ack);
    send_byte(8'h0E, ack); m_ptr = 4'hE;
    bus_start();
    send_byte(8'h85, ack); m_snap = status;
    for (int i = 0; i < 3; i++) begin
      rexp_q.push_back(mdl_rd(m_ptr));
      recv_byte(i == 2, b);
      if (i < 2) m_ptr = m_ptr + 4'd1;
      e = rexp_q.pop_front();
      total++; if (b !== e) $display("FAIL rd_wrap[%0d]: got %h want %h", i, b, e); else passed++;
      if (i == 0) begin
        total++; if (b !== 8'hA5) $display("FAIL rd_id: got %h want a5", b); else passed++;
      end
    end
    bus_stop();
    total++; if (strobes != s0) $display("FAIL rd_no_commit: got %0d want %0d", strobes, s0); else passed++;
  endtask

  task automatic test_pointer_wrap();
    logic ack;
    logic [7:0] d [7];
    logic [95:0] e, o;
    for (int i = 0; i < 7; i++) d[i] = 8'($urandom_range(1, 255));
    bus_start();
    send_byte(8'h84, ack);
    send_byte(8'h0B, ack); m_ptr = 4'hB;
    for (int i = 0; i < 7; i++) begin
      send_byte(d[i], ack); mdl_write(d[i]);
      total++; if (ack !== 1'b0) $display("FAIL wrap_ack[%0d]: got %b want 0", i, ack); else passed++;
    end
    bus_stop();
    total++;
    if (obs_q.size() == 0 || exp_q.size() == 0) $display("FAIL wrap_commit: got %0d commits want %0d", obs_q.size(), exp_q.size());
    else begin
      o = obs_q.pop_front(); e = exp_q.pop_front();
      if (o !== e) $display("FAIL wrap_commit: got %h want %h", o, e); else passed++;
    end
    total++; if (cfg[95:88] !== d[0]) $display("FAIL wrap_b11: got %h want %h", cfg[95:88], d[0]); else passed++;
    total++; if (cfg[7:0] !== d[5]) $display("FAIL wrap_b0: got %h want %h", cfg[7:0], d[5]); else passed++;
    total++; if (cfg[15:8] !== d[6]) $display("FAIL wrap_b1: got %h want %h", cfg[15:8], d[6]); else passed++;
  endtask

  task automatic test_reset_mid_write();
    logic ack;
    logic [95:0] e, o;
    bus_start();
    send_byte(8'h84, ack);
    send_byte(8'h02, ack);
    send_bit(1'b0);
    send_bit(1'b1);
    @(negedge clk); rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    mdl_reset();
    @(negedge clk);
    total++; if (sda_oe !== 1'b0) $display("FAIL rst_oe: got %b want 0", sda_oe); else passed++;
    total++; if (cfg !== 96'h0) $display("FAIL rst_cfg: got %h want 0", cfg); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", busy); else passed++;
    bus_stop();
    bus_start();
    send_byte(8'h84, ack);
    total++; if (ack !== 1'b0) $display("FAIL rst_re_addr_ack: got %b want 0", ack); else passed++;
    send_byte(8'h04, ack); m_ptr = 4'h4;
    for (int i = 0; i < 3; i++) begin
      send_byte(8'h31 + 8'(i), ack); mdl_write(8'h31 + 8'(i));
      total++; if (ack !== 1'b0) $display("FAIL rst_re_ack[%0d]: got %b want 0", i, ack); else passed++;
    end
    bus_stop();
    total++;
    if (obs_q.size() == 0 || exp_q.size() == 0) $display("FAIL rst_re_commit: got %0d commits want %0d", obs_q.size(), exp_q.size());
    else begin
      o = obs_q.pop_front(); e = exp_q.pop_front();
      if (o !== e) $display("FAIL rst_re_commit: got %h want %h", o, e); else passed++;
    end
  endtask

  task automatic test_glitch();
    logic ack;
    logic [7:0] b, eb;
    logic [95:0] e, o;
    b = 8'hB2;
`ifdef I2C_CFG_TARGET_FILTER_EN
    eb = b;
`else
    eb = {b[7:4], b[4:1]};  // the glitch adds an extra copy of bit 4
`endif
    bus_start();
    send_byte(8'h84, ack);
    send_byte(8'h05, ack); m_ptr = 4'h5;
    for (int i = 7; i >= 0; i--) begin
      m_sda = b[i]; #Q; m_scl = 1'b1; #Q;
      if (i == 4) begin
        m_scl = 1'b0; #20; m_scl = 1'b1;
      end
      #Q; m_scl = 1'b0; #Q;
    end
    m_sda = 1'b1; #Q; m_scl = 1'b1; #(2*Q); m_scl = 1'b0; #Q;
    mdl_write(eb);
    bus_stop();
    total++;
    if (obs_q.size() == 0 || exp_q.size() == 0) $display("FAIL glitch_commit: got %0d commits want %0d", obs_q.size(), exp_q.size());
    else begin
      o = obs_q.pop_front(); e = exp_q.pop_front();
      if (o !== e) $display("FAIL glitch_commit: got %h want %h", o, e); else passed++;
    end
    total++; if (cfg[47:40] !== eb) $display("FAIL glitch_byte: got %h want %h", cfg[47:40], eb); else passed++;
  endtask

  initial begin
    test_reset();
    test_addressed_write();
    test_wrong_address();
    test_read_snapshot();
    test_pointer_wrap();
    test_reset_mid_write();
    test_glitch();
    repeat (20) @(negedge clk);
    total++;
    if (obs_q.size() != 0 || exp_q.size() != 0)
      $display("FAIL leftover_commits: got %0d observed want %0d expected", obs_q.size(), exp_q.size());
    else passed++;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
